kuuga_bram_bridge: RTL

- Adapts the core's req/gnt/rvalid data-memory port to a single-port BRAM with fixed read latency.
- Sits between the core and one BRAM instance: data or instruction, one bridge per memory.
- Converts byte addresses to word addresses and issues BRAM enable and byte-write strobes.
- Realigns BRAM read data to a response FIFO that the consumer can backpressure, with credit-based grant so no response is ever lost.

---
 rtl/kuuga_bram_bridge_if.sv | 23 ++
 rtl/kuuga_bram_bridge.sv | 131 +++++++++++++
 2 files changed

// File: rtl/kuuga_bram_bridge_if.sv
// Core-side data-memory port: req/gnt request channel plus rvalid/rready response channel.
interface kuuga_bram_bridge_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        rerr_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, rerr_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, rerr_o
    );
endinterface

// File: rtl/kuuga_bram_bridge.sv
// Bridges the core req/gnt/rvalid memory port onto a fixed-latency single-port BRAM,
// realigning read data into a credit-protected response FIFO.
module kuuga_bram_bridge #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kuuga_bram_bridge_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_wrdata,
    input  logic [31:0]           bram_rddata,
    output logic                  bram_rst
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(RESP_DEPTH + READ_LATENCY + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    logic [31:0]             offset;
    logic                    in_range;
    logic                    accept;
    logic                    has_credit;
    logic [OCC_W-1:0]        occupancy;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_we;
    logic [READ_LATENCY-1:0] pipe_err;

    resp_t                   fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    push;
    logic                    pop;
    resp_t                   push_resp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Window decode and credit: occupancy counts queued plus in-flight responses.
    always_comb begin
        offset    = bus.addr_i - BASE_ADDR;
        in_range  = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < READ_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(pipe_valid[i]);
        end
        has_credit = occupancy < OCC_W'(RESP_DEPTH);
    end

    assign bus.gnt_o = bus.req_i & has_credit & ~bram_rst;
    assign accept    = bus.req_i & bus.gnt_o;

    // BRAM is driven in the accept cycle; out-of-range accesses leave it idle.
    assign bram_en     = accept & in_range;
    assign bram_we     = (accept & bus.we_i & in_range) ? bus.be_i : 4'b0000;
    assign bram_addr   = offset[ADDR_WIDTH+1:2];
    assign bram_wrdata = bus.wdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bram_rst <= 1'b1;
        else        bram_rst <= 1'b0;
    end

    // Latency shadow of the BRAM read pipe; the last stage lines up with bram_rddata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_we    <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_we[0]    <= bus.we_i;
            pipe_err[0]   <= ~in_range;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_we[i]    <= pipe_we[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    always_comb begin
        push           = pipe_valid[READ_LATENCY-1];
        push_resp.err  = pipe_err[READ_LATENCY-1];
        push_resp.data = (~pipe_we[READ_LATENCY-1] & ~pipe_err[READ_LATENCY-1])
                         ? bram_rddata : '0;
    end

    assign bus.rvalid_o = (fifo_count != '0);
    assign pop          = bus.rvalid_o & bus.rready_i;
    assign bus.rdata_o  = bus.rvalid_o ? fifo_mem[rd_ptr].data : '0;
    assign bus.rerr_o   = bus.rvalid_o & fifo_mem[rd_ptr].err;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_resp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credit accounting must make a push into a full FIFO without a pop impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_count == CNT_W'(RESP_DEPTH)));

endmodule
